dmi_jtag_dr: RTL
================

// Module: dmi_jtag_dr
// PURPOSE
//  DR-side logic downstream of the debug TAP (DTM per debug spec 0.13).
//  - Owns the DTMCS and DMI shift registers, driven by the TAP's capture/shift/update strobes.
//  - Turns each completed DMI scan into one valid/ready request toward the Debug Module.
//  - Captures the DM response and reports sticky busy/failed status on the next DMI capture.
//  - Runs entirely in the TCK domain.
// PARAMETERS
//  AbitsWidth  7  DMI address width; also reported in dtmcs.abits.
//  IdleHint    1  Value reported in dtmcs.idle[14:12]; saturates at 7.
// PORTS
//  clk_i             in   1             TCK from the TAP.
//  rst_i             in   1             Synchronous, active-high reset.
//  capture_i         in   1             TAP in Capture-DR.
//  shift_i           in   1             TAP in Shift-DR.
//  update_i          in   1             TAP in Update-DR.
//  tdi_i             in   1             Serial data in.
//  dtmcs_select_i    in   1             IR = DTMCS.
//  dmi_select_i      in   1             IR = DMIACCESS.
//  dtmcs_tdo_o       out  1             dtmcs_sr[0].
//  dmi_tdo_o         out  1             dmi_sr[0].
//  dmi_req_valid_o   out  1             Request valid.
//  dmi_req_ready_i   in   1             DM accepts the request.
//  dmi_req_addr_o    out  AbitsWidth    Request address.
//  dmi_req_data_o    out  32            Write data.
//  dmi_req_op_o      out  2             1 = read, 2 = write.
//  dmi_resp_valid_i  in   1             Response valid.
//  dmi_resp_ready_o  out  1             Block accepts the response.
//  dmi_resp_data_i   in   32            Read data.
//  dmi_resp_resp_i   in   2             0 = ok; nonzero = failed.
//  dmi_hardreset_o   out  1             One-cycle pulse on dtmcs.dmihardreset.
// BEHAVIOUR
//  Reset (rst_i=1 at posedge): state=Idle, err_q=0, addr_q/data_q/shift regs=0; all outputs 0.
//  DTMCS value = {14'b0, 2'b0, 1'b0, IdleHint[2:0], err_q, 6'(AbitsWidth), 4'd1}; read-only except bits 17:16.
//  DTMCS DR (32 bit, active when dtmcs_select_i):
//   - capture_i: load DTMCS value.
//   - shift_i: sr = {tdi_i, sr[31:1]}.
//   - update_i, sr[16]=1 (dmireset): err_q<=0.
//   - update_i, sr[17]=1 (dmihardreset): err_q<=0; state->Idle, abandoning any transfer;
//     dmi_hardreset_o=1 for exactly that one cycle.
//  DMI DR (AbitsWidth+34 bit, {addr,data,op}, LSB first, active when dmi_select_i):
//   - capture_i: sr = {addr_q, data_q, st}; st = 2'b11 if state!=Idle, else err_q.
//     Capturing while state!=Idle also sets err_q=3.
//   - shift_i: right shift, tdi_i into the MSB.
//   - update_i decoded only when err_q==0:
//     - op=1: state Idle->Read; addr_q<=sr addr.
//     - op=2: state Idle->Write; addr_q<=sr addr; data_q<=sr data.
//     - op=0 or op=3: no-op.
//   - update_i with state!=Idle: ignored, err_q<=3.
//   - update_i with err_q!=0 and state==Idle: ignored, err_q unchanged.
//  FSM states: Idle, Read, WaitRead, Write, WaitWrite.
//   - Read/Write: dmi_req_valid_o=1; addr/data/op held stable until dmi_req_ready_i,
//     then ->WaitRead/WaitWrite. No valid deassert before handshake.
//   - WaitRead/WaitWrite: dmi_resp_ready_o=1; on dmi_resp_valid_i ->Idle.
//     - WaitRead with resp==0: data_q<=resp_data.
//     - Any resp!=0: err_q<=2; data_q unchanged.
//   - Response is only accepted in the Wait states; resp_valid in other states is ignored.
//  Latency: request valid in the cycle after Update-DR; a ready=1 DM completes the
//   request phase in 1 cycle. Response ready is asserted the cycle after the request handshake.
//  Priority in one cycle: rst_i > dmihardreset > response handshake > DMI update.
//   The sticky busy set by capture-while-busy dominates a same-cycle response err_q write.
//  err_q is cleared only by reset, dmireset, or dmihardreset.
//  Neither select asserted: shift registers hold; both select asserted is illegal (assertion).
// TESTING
//  T1 Reset -> DTMCS capture+shift out 32 bits reads 0x00001071 (AbitsWidth=7, IdleHint=1).
//  T2 Write: DMI scan addr=0x10, data=0xDEADBEEF, op=2, DM ready=1 ->
//     req_valid 1 cycle, addr 0x10, data 0xDEADBEEF, op 2; resp ok;
//     next capture st=0.
//  T3 Read: DM holds ready=0 for 5 cycles ->
//     valid/addr stable all 5 cycles; resp_data=0x12345678;
//     next capture returns data 0x12345678, st=0.
//  T4 Busy: capture while WaitRead -> st=3, err_q=3;
//     following update op=2 is ignored (no request);
//     DTMCS write bit16=1 -> dmistat=0.
//  T5 Failed: resp_resp_i=2 on a read -> next capture st=2;
//     later op=1 scans issue no request until dmireset.
//  T6 Hardreset: bit17 written during WaitWrite ->
//     dmi_hardreset_o 1-cycle pulse, FSM Idle, resp_ready_o=0;
//     rst_i mid-transfer -> all outputs 0 next cycle.

Source files
------------

// File: rtl/dmi_jtag_dr.sv
// ----------------------------------------------------------------------------
// dmi_jtag_dr
//
// Data-register side of a RISC-V debug transport module, sitting behind the
// JTAG TAP controller and clocked by TCK. It owns the DTMCS and DMI shift
// registers, turns each completed DMI scan into a single valid/ready request
// toward the Debug Module, captures the DM response and reports sticky
// busy/failed status on the next DMI capture.
//
// Ports
//   clk_i, rst_i                 TCK and synchronous active-high reset
//   capture_i/shift_i/update_i   TAP Capture-DR / Shift-DR / Update-DR strobes
//   tdi_i                        serial data in
//   dtmcs_select_i, dmi_select_i IR currently selects DTMCS / DMIACCESS
//   dtmcs_tdo_o, dmi_tdo_o       LSB of the respective shift register
//   dmi_req_*                    request channel toward the DM
//   dmi_resp_*                   response channel from the DM
//   dmi_hardreset_o              one-cycle pulse when dtmcs.dmihardreset is written
// ----------------------------------------------------------------------------
module dmi_jtag_dr #(
    parameter int AbitsWidth = 7,
    parameter int IdleHint   = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  capture_i,
    input  logic                  shift_i,
    input  logic                  update_i,
    input  logic                  tdi_i,
    input  logic                  dtmcs_select_i,
    input  logic                  dmi_select_i,
    output logic                  dtmcs_tdo_o,
    output logic                  dmi_tdo_o,
    output logic                  dmi_req_valid_o,
    input  logic                  dmi_req_ready_i,
    output logic [AbitsWidth-1:0] dmi_req_addr_o,
    output logic [31:0]           dmi_req_data_o,
    output logic [1:0]            dmi_req_op_o,
    input  logic                  dmi_resp_valid_i,
    output logic                  dmi_resp_ready_o,
    input  logic [31:0]           dmi_resp_data_i,
    input  logic [1:0]            dmi_resp_resp_i,
    output logic                  dmi_hardreset_o
);

    localparam int         DmiWidth   = AbitsWidth + 34;
    localparam logic [2:0] IdleField  = (IdleHint > 7) ? 3'd7 : 3'(IdleHint);
    localparam logic [5:0] AbitsField = 6'(AbitsWidth);

    localparam logic [1:0] OpRead   = 2'd1;
    localparam logic [1:0] OpWrite  = 2'd2;
    localparam logic [1:0] ErrFail  = 2'd2;
    localparam logic [1:0] ErrBusy  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WAIT_READ,
        ST_WRITE,
        ST_WAIT_WRITE
    } state_t;

    state_t                r_state;
    logic [1:0]            r_err;
    logic [AbitsWidth-1:0] r_addr;
    logic [31:0]           r_data;
    logic [31:0]           r_dtmcs_sr;
    logic [DmiWidth-1:0]   r_dmi_sr;
    logic                  r_req_valid;
    logic [1:0]            r_req_op;
    logic                  r_resp_ready;
    logic                  r_hardreset;

    logic                  w_dtmcs_capture;
    logic                  w_dtmcs_shift;
    logic                  w_dtmcs_update;
    logic                  w_dmi_capture;
    logic                  w_dmi_shift;
    logic                  w_dmi_update;
    logic                  w_busy;
    logic                  w_resp_fire;
    logic [1:0]            w_capture_status;
    logic [31:0]           w_dtmcs_value;
    logic [AbitsWidth-1:0] w_sr_addr;
    logic [31:0]           w_sr_data;
    logic [1:0]            w_sr_op;

    assign w_dtmcs_capture = dtmcs_select_i & capture_i;
    assign w_dtmcs_shift   = dtmcs_select_i & shift_i;
    assign w_dtmcs_update  = dtmcs_select_i & update_i;
    assign w_dmi_capture   = dmi_select_i & capture_i;
    assign w_dmi_shift     = dmi_select_i & shift_i;
    assign w_dmi_update    = dmi_select_i & update_i;

    assign w_busy      = (r_state != ST_IDLE);
    assign w_resp_fire = dmi_resp_valid_i &
                         ((r_state == ST_WAIT_READ) || (r_state == ST_WAIT_WRITE));

    // A transfer still in flight is reported as busy regardless of the sticky error.
    assign w_capture_status = w_busy ? ErrBusy : r_err;

    assign w_dtmcs_value = {14'b0, 2'b0, 1'b0, IdleField, r_err, AbitsField, 4'd1};

    // DMI shift register layout, LSB first: {addr, data, op}.
    assign w_sr_addr = r_dmi_sr[DmiWidth-1:34];
    assign w_sr_data = r_dmi_sr[33:2];
    assign w_sr_op   = r_dmi_sr[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_err        <= 2'd0;
            r_addr       <= '0;
            r_data       <= '0;
            r_dtmcs_sr   <= '0;
            r_dmi_sr     <= '0;
            r_req_valid  <= 1'b0;
            r_req_op     <= 2'd0;
            r_resp_ready <= 1'b0;
            r_hardreset  <= 1'b0;
        end else begin
            r_hardreset <= 1'b0;

            // Shift registers only move while their instruction is selected.
            if (w_dtmcs_capture) begin
                r_dtmcs_sr <= w_dtmcs_value;
            end else if (w_dtmcs_shift) begin
                r_dtmcs_sr <= {tdi_i, r_dtmcs_sr[31:1]};
            end

            if (w_dmi_capture) begin
                r_dmi_sr <= {r_addr, r_data, w_capture_status};
            end else if (w_dmi_shift) begin
                r_dmi_sr <= {tdi_i, r_dmi_sr[DmiWidth-1:1]};
            end

            // Transfer FSM; output registers are updated together with the state.
            case (r_state)
                ST_IDLE: begin
                    if (w_dmi_update && (r_err == 2'd0)) begin
                        if (w_sr_op == OpRead) begin
                            r_state     <= ST_READ;
                            r_addr      <= w_sr_addr;
                            r_req_valid <= 1'b1;
                            r_req_op    <= OpRead;
                        end else if (w_sr_op == OpWrite) begin
                            r_state     <= ST_WRITE;
                            r_addr      <= w_sr_addr;
                            r_data      <= w_sr_data;
                            r_req_valid <= 1'b1;
                            r_req_op    <= OpWrite;
                        end
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (dmi_req_ready_i) begin
                        r_state      <= (r_state == ST_READ) ? ST_WAIT_READ : ST_WAIT_WRITE;
                        r_req_valid  <= 1'b0;
                        r_req_op     <= 2'd0;
                        r_resp_ready <= 1'b1;
                    end
                end
                ST_WAIT_READ, ST_WAIT_WRITE: begin
                    if (dmi_resp_valid_i) begin
                        r_state      <= ST_IDLE;
                        r_resp_ready <= 1'b0;
                        if (dmi_resp_resp_i != 2'd0) begin
                            r_err <= ErrFail;
                        end else if (r_state == ST_WAIT_READ) begin
                            r_data <= dmi_resp_data_i;
                        end
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_req_valid  <= 1'b0;
                    r_req_op     <= 2'd0;
                    r_resp_ready <= 1'b0;
                end
            endcase

            // An update that lands on a busy transfer is dropped and flagged,
            // unless the response completes in that same cycle.
            if (w_dmi_update && w_busy && !w_resp_fire) begin
                r_err <= ErrBusy;
            end

            // Capture-while-busy is written after the response so it wins.
            if (w_dmi_capture && w_busy) begin
                r_err <= ErrBusy;
            end

            // dmireset / dmihardreset clear the sticky error.
            if (w_dtmcs_update && (r_dtmcs_sr[16] || r_dtmcs_sr[17])) begin
                r_err <= 2'd0;
            end

            // dmihardreset abandons whatever transfer is in progress.
            if (w_dtmcs_update && r_dtmcs_sr[17]) begin
                r_state      <= ST_IDLE;
                r_req_valid  <= 1'b0;
                r_req_op     <= 2'd0;
                r_resp_ready <= 1'b0;
                r_hardreset  <= 1'b1;
            end
        end
    end

    assign dtmcs_tdo_o      = r_dtmcs_sr[0];
    assign dmi_tdo_o        = r_dmi_sr[0];
    assign dmi_req_valid_o  = r_req_valid;
    assign dmi_req_addr_o   = r_addr;
    assign dmi_req_data_o   = r_data;
    assign dmi_req_op_o     = r_req_op;
    assign dmi_resp_ready_o = r_resp_ready;
    assign dmi_hardreset_o  = r_hardreset;

    // The TAP decodes one instruction at a time.
    a_one_select : assert property (@(posedge clk_i) disable iff (rst_i)
                                    !(dtmcs_select_i && dmi_select_i));

endmodule
